msk_aes_stream_host: RTL and testbench

//  Initiator-side front-end for the masked 32-bit AES core. Deserialises a 32-bit word stream

---
 rtl/msk_aes_stream_host.sv | 132 +++++++++++++
 tb/tb_msk_aes_stream_host.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/msk_aes_stream_host.sv
// Stream front-end for the masked AES core: deserialises 32-bit words into the
// plaintext/key buses, runs the core handshakes, and serialises the ciphertext back out.
module msk_aes_stream_host #(
  parameter int d = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [31:0]        s_data,
  input  logic               s_valid,
  output logic               s_ready,
  output logic [31:0]        m_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic               m_last,
  output logic               busy,
  output logic               core_valid_in,
  input  logic               core_in_ready,
  output logic [128*d-1:0]   core_sh_plaintext,
  output logic [256*d-1:0]   core_sh_key,
  input  logic               core_cipher_valid,
  output logic               core_out_ready,
  input  logic [128*d-1:0]   core_sh_ciphertext
);

  localparam int NIN  = 12 * d;
  localparam int NOUT = 4 * d;
  localparam int CW   = $clog2(NIN);
  localparam int PW   = $clog2(4 * d);
  localparam int KW   = $clog2(8 * d);

  typedef enum logic [1:0] {S_LOAD, S_ISSUE, S_WAIT, S_UNLOAD} state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [CW-1:0]          r_in_cnt;
  logic [CW-1:0]          r_out_cnt;
  logic [4*d-1:0][31:0]   r_pt;
  logic [8*d-1:0][31:0]   r_key;
  logic [4*d-1:0][31:0]   r_ct;
  logic                   r_started;
  logic                   w_in_fire;
  logic                   w_out_fire;
  logic                   w_in_last;
  logic                   w_out_last;
  logic [KW-1:0]          w_key_idx;

  assign w_in_fire  = s_valid & s_ready;
  assign w_out_fire = m_valid & m_ready;
  assign w_in_last  = (r_in_cnt == CW'(NIN - 1));
  assign w_out_last = (r_out_cnt == CW'(NOUT - 1));
  assign w_key_idx  = KW'(r_in_cnt - CW'(4 * d));

  assign core_sh_plaintext = r_pt;
  assign core_sh_key       = r_key;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_LOAD;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_LOAD:   if (w_in_fire && w_in_last)   w_next = S_ISSUE;
      S_ISSUE:  if (core_in_ready)            w_next = S_WAIT;
      S_WAIT:   if (core_cipher_valid)        w_next = S_UNLOAD;
      S_UNLOAD: if (w_out_fire && w_out_last) w_next = S_LOAD;
      default:                                w_next = S_LOAD;
    endcase
  end

  always_comb begin
    s_ready        = 1'b0;
    core_valid_in  = 1'b0;
    core_out_ready = 1'b0;
    m_valid        = 1'b0;
    m_last         = 1'b0;
    m_data         = '0;
    busy           = !((r_state == S_LOAD) && (r_in_cnt == '0));
    case (r_state)
      // r_started keeps s_ready low while reset is held and for the release cycle
      S_LOAD:   s_ready = r_started;
      S_ISSUE:  core_valid_in = 1'b1;
      S_WAIT:   core_out_ready = 1'b1;
      S_UNLOAD: begin
        m_valid = 1'b1;
        m_last  = w_out_last;
        m_data  = r_ct[r_out_cnt[PW-1:0]];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_in_cnt  <= '0;
      r_out_cnt <= '0;
      r_pt      <= '0;
      r_key     <= '0;
      r_ct      <= '0;
      r_started <= 1'b0;
    end else begin
      r_started <= 1'b1;
      if (w_in_fire) begin
        if (r_in_cnt < CW'(4 * d)) r_pt[r_in_cnt[PW-1:0]] <= s_data;
        else                       r_key[w_key_idx]       <= s_data;
        r_in_cnt <= w_in_last ? '0 : r_in_cnt + CW'(1);
      end
      if ((r_state == S_ISSUE) && core_in_ready) begin
        r_pt  <= '0;
        r_key <= '0;
      end
      if ((r_state == S_WAIT) && core_cipher_valid) begin
        r_ct <= core_sh_ciphertext;
      end
      // each emitted share slice is wiped as soon as downstream takes it
      if (w_out_fire) begin
        if (w_out_last) begin
          r_ct      <= '0;
          r_out_cnt <= '0;
        end else begin
          r_ct[r_out_cnt[PW-1:0]] <= '0;
          r_out_cnt               <= r_out_cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_msk_aes_stream_host.sv
// Scoreboard bench for msk_aes_stream_host (d=2): directed transactions, a core stub,
// and an output monitor that pops expected words from a queue.
module tb_msk_aes_stream_host;

  localparam int D    = 2;
  localparam int NIN  = 12 * D;
  localparam int NOUT = 4 * D;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [31:0]        s_data;
  logic               s_valid;
  logic               s_ready;
  logic [31:0]        m_data;
  logic               m_valid;
  logic               m_ready;
  logic               m_last;
  logic               busy;
  logic               core_valid_in;
  logic               core_in_ready;
  logic [128*D-1:0]   core_sh_plaintext;
  logic [256*D-1:0]   core_sh_key;
  logic               core_cipher_valid;
  logic               core_out_ready;
  logic [128*D-1:0]   core_sh_ciphertext;

  logic               stub_cv;
  logic               spur_cv;
  logic [128*D-1:0]   stub_ct;
  logic [128*D-1:0]   spur_ct;

  int                 errors = 0;
  int                 checks = 0;
  int                 pop_cnt = 0;
  int                 ir_delay = 0;
  exp_t               sb_q[$];
  logic [128*D-1:0]   exp_pt;
  logic [256*D-1:0]   exp_key;

  assign core_cipher_valid  = stub_cv | spur_cv;
  assign core_sh_ciphertext = spur_cv ? spur_ct : stub_ct;

  always #5 clk = ~clk;

  msk_aes_stream_host #(.d(D)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .s_data             (s_data),
    .s_valid            (s_valid),
    .s_ready            (s_ready),
    .m_data             (m_data),
    .m_valid            (m_valid),
    .m_ready            (m_ready),
    .m_last             (m_last),
    .busy               (busy),
    .core_valid_in      (core_valid_in),
    .core_in_ready      (core_in_ready),
    .core_sh_plaintext  (core_sh_plaintext),
    .core_sh_key        (core_sh_key),
    .core_cipher_valid  (core_cipher_valid),
    .core_out_ready     (core_out_ready),
    .core_sh_ciphertext (core_sh_ciphertext)
  );

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Output monitor: compares every accepted word against the scoreboard head
  initial begin : monitor
    exp_t        e;
    logic        stall;
    logic [31:0] held;
    stall = 1'b0;
    held  = '0;
    forever begin
      @(negedge clk);
      if (m_valid) begin
        if (stall) check("hold_data", m_data, held);
        if (m_ready) begin
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL extra_word: got %h expected none", m_data);
          end else begin
            e = sb_q.pop_front();
            check("m_data", m_data, e.data);
            check("m_last", m_last, e.last);
            pop_cnt++;
          end
        end
        stall = !m_ready;
        held  = m_data;
      end else begin
        stall = 1'b0;
        check("m_data_idle", m_data, 0);
      end
    end
  end

  // Core stub: accepts after ir_delay cycles, returns pt ^ key[255:0] five cycles later
  initial begin : core_stub
    int               phase;
    int               wcnt;
    logic             dropped;
    logic [128*D-1:0] cap_pt;
    logic [256*D-1:0] cap_key;
    phase = 0; wcnt = 0; dropped = 1'b0;
    core_in_ready = 1'b0;
    stub_cv = 1'b0;
    stub_ct = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        phase = 0; wcnt = 0; dropped = 1'b0;
        core_in_ready = 1'b0;
        stub_cv = 1'b0;
      end else begin
        case (phase)
          0: begin
            if (core_valid_in) begin
              if (wcnt < ir_delay) begin
                wcnt++;
              end else begin
                core_in_ready = 1'b1;
                cap_pt  = core_sh_plaintext;
                cap_key = core_sh_key;
                check("hs_pt", cap_pt, exp_pt);
                check("hs_key", cap_key, exp_key);
                check("vin_held", dropped, 0);
                phase = 1;
              end
            end else if (wcnt > 0) begin
              dropped = 1'b1;
            end
          end
          1: begin
            core_in_ready = 1'b0;
            wcnt = 0;
            dropped = 1'b0;
            check("pt_zero", core_sh_plaintext, 0);
            check("key_zero", core_sh_key, 0);
            check("vin_low_wait", core_valid_in, 0);
            check("out_ready_wait", core_out_ready, 1);
            phase = 2;
          end
          2: begin
            wcnt++;
            if (wcnt == 5) begin
              stub_cv = 1'b1;
              stub_ct = cap_pt ^ cap_key[128*D-1:0];
              phase = 3;
            end
          end
          default: begin
            stub_cv = 1'b0;
            stub_ct = {8{32'hA5A5_0F0F}};
            wcnt = 0;
            phase = 0;
          end
        endcase
      end
    end
  end

  task automatic put_word(input logic [31:0] w);
    int n;
    n = 0;
    s_data  = w;
    s_valid = 1'b1;
    @(negedge clk);
    while (!s_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!s_ready) begin
      checks++;
      errors++;
      $display("FAIL s_ready_timeout: got 0 expected 1");
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
    s_data  = '0;
  endtask

  task automatic pulse_spur(input int at_cnt);
    spur_cv = 1'b1;
    @(posedge clk); #1;
    spur_cv = 1'b0;
    @(negedge clk);
    check("spur_ct", dut.r_ct, 0);
    check("spur_mvalid", m_valid, 0);
    check("spur_oready", core_out_ready, 0);
    check("spur_cnt", dut.r_in_cnt, at_cnt);
    @(posedge clk); #1;
  endtask

  task automatic send_txn(input logic [31:0] base, input int spur_at);
    exp_t e;
    for (int k = 0; k < 4 * D; k++) exp_pt[32*k +: 32] = base + 32'(k);
    for (int k = 0; k < 8 * D; k++) exp_key[32*k +: 32] = base + 32'(4 * D + k);
    for (int j = 0; j < NOUT; j++) begin
      e.data = (base + 32'(j)) ^ (base + 32'(4 * D + j));
      e.last = (j == NOUT - 1);
      sb_q.push_back(e);
    end
    for (int k = 0; k < NIN; k++) begin
      if (k == spur_at) pulse_spur(k);
      put_word(base + 32'(k));
    end
    @(negedge clk);
    check("vin_after_last", core_valid_in, 1);
    check("s_ready_issue", s_ready, 0);
  endtask

  task automatic drain(input logic rnd, input int leave);
    int tgt;
    int n;
    tgt = pop_cnt + sb_q.size() - leave;
    n = 0;
    while (pop_cnt < tgt && n < 2000) begin
      m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); #1;
      n++;
    end
    m_ready = 1'b0;
    if (pop_cnt < tgt) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d words expected %0d", pop_cnt, tgt);
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    rst_n   = 1'b0;
    s_valid = 1'b1;
    s_data  = 32'hFFFF_FFFF;
    m_ready = 1'b0;
    spur_cv = 1'b0;
    spur_ct = {8{32'hDEAD_BEEF}};

    // Reset held for 3 cycles with s_valid asserted
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_s_ready", s_ready, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_vin", core_valid_in, 0);
    check("rst_pt", core_sh_plaintext, 0);
    check("rst_key", core_sh_key, 0);
    check("rst_busy", busy, 0);
    check("rst_m_data", m_data, 0);
    @(posedge clk); #1;
    rst_n   = 1'b1;
    s_valid = 1'b0;
    s_data  = '0;
    @(negedge clk);
    check("rel_s_ready0", s_ready, 0);
    @(negedge clk);
    check("rel_s_ready1", s_ready, 1);
    @(posedge clk); #1;

    // Full transaction, words 0..23
    ir_delay = 0;
    send_txn(32'h0000_0000, -1);
    drain(1'b0, 0);
    @(negedge clk);
    check("busy_done", busy, 0);
    @(posedge clk); #1;

    // Backpressure on both handshakes
    ir_delay = 10;
    send_txn(32'h0A0B_0000, -1);
    drain(1'b1, 0);
    ir_delay = 0;

    // Spurious cipher_valid in LOAD (idle and mid-load), spurious s_valid in WAIT/UNLOAD
    pulse_spur(0);
    send_txn(32'h0000_5000, 7);
    s_valid = 1'b1;
    s_data  = 32'h5EEE_5EEE;
    drain(1'b0, 1);
    s_valid = 1'b0;
    s_data  = '0;
    drain(1'b0, 0);
    @(negedge clk);
    check("spur_in_cnt", dut.r_in_cnt, 0);
    check("spur_pt_clean", dut.r_pt, 0);
    check("spur_busy", busy, 0);
    @(posedge clk); #1;

    // Reset mid-UNLOAD after word 3
    send_txn(32'h0000_0100, -1);
    drain(1'b0, NOUT - 4);
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("midrst_mvalid", m_valid, 0);
    check("midrst_ct", dut.r_ct, 0);
    check("midrst_vin", core_valid_in, 0);
    sb_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    send_txn(32'h0000_0200, -1);
    drain(1'b1, 0);

    // Back-to-back transactions with distinct data
    send_txn(32'h1000_0000, -1);
    drain(1'b0, 0);
    @(negedge clk);
    check("b2b_ct_zero", dut.r_ct, 0);
    check("b2b_pt_zero", dut.r_pt, 0);
    check("b2b_key_zero", dut.r_key, 0);
    @(posedge clk); #1;
    send_txn(32'hFFFF_0000, -1);
    drain(1'b0, 0);
    @(negedge clk);
    check("end_queue_empty", sb_q.size(), 0);
    check("end_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
